// File: rtl/freq_meter_if.sv
// freq_meter_if: control, measured signal and result bundle of the frequency meter
interface freq_meter_if #(parameter int W = 26);
  logic         en;
  logic         sig_in;
  logic [W-1:0] freq;
  logic         valid;
  logic         ovf;
  logic         busy;
  modport master (output en, sig_in, input freq, valid, ovf, busy);
  modport slave (input en, sig_in, output freq, valid, ovf, busy);
endinterface

// File: rtl/freq_meter.sv
// freq_meter: counts sig_in rising edges over back-to-back M-cycle gate windows
module freq_meter #(
  parameter int N = 26,
  parameter int M = 50000000,
  parameter int W = 26
) (
  input logic          clk,
  input logic          reset,
  freq_meter_if.slave  bus
);
  typedef enum logic {IDLE, GATE} state_t;
  state_t       state_q, state_d;
  logic         s1_q, s2_q, s3_q;
  logic [N-1:0] gate_cnt_q, gate_cnt_d;
  logic [W-1:0] edge_cnt_q, edge_cnt_d, edge_inc;
  logic [W-1:0] freq_q, freq_d;
  logic         sat_q, sat_d, ovf_q, ovf_d, valid_q, valid_d, busy_q, busy_d;
  logic         rise, sat_hit, active, last, run, done;
  // en alone picks the next state: every path with en low ends in IDLE, with en high in GATE
  always_comb begin
    rise       = s2_q & ~s3_q;
    sat_hit    = (&edge_cnt_q) & rise;
    edge_inc   = (&edge_cnt_q) ? edge_cnt_q : edge_cnt_q + W'(rise);
    active     = state_q == GATE;
    last       = gate_cnt_q == N'(M - 1);
    run        = active & bus.en & ~last;
    done       = active & last;
    state_d    = bus.en ? GATE : IDLE;
    busy_d     = bus.en;
    gate_cnt_d = run ? gate_cnt_q + 1'b1 : '0;
    edge_cnt_d = run ? edge_inc : '0;
    sat_d      = run & (sat_q | sat_hit);
    valid_d    = done;
    freq_d     = done ? edge_inc : freq_q;
    ovf_d      = done ? (sat_q | sat_hit) : ovf_q;
  end
  // synchronizer keeps running in IDLE so edge history is current at window start
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      s1_q       <= bus.sig_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      freq_q     <= freq_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end
  assign bus.freq  = freq_q;
  assign bus.valid = valid_q;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = busy_q;
endmodule
